// File: rtl/piso_pkg.sv
// Shared definitions for the parallel-in, serial-out serializer: FSM state
// encodings and the bit-counter width helper.
package piso_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

  // A down-counter from width-1 to 0 needs ceil(log2(width)) bits; keep at least one.
  function automatic int CNT_W(input int width);
    return (width > 1) ? $clog2(width) : 1;
  endfunction

endpackage

// File: rtl/shift_reg_en.sv
// WIDTH-bit register with asynchronous reset, synchronous parallel load,
// synchronous clear and an enabled zero-filling shift in direction DIR.
module shift_reg_en #(
  parameter int WIDTH = 8,
  parameter int DIR   = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             clear,
  input  logic             shift,
  input  logic [WIDTH-1:0] load_data,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] q_d;

  // Load wins over clear, clear wins over shift; DIR=1 moves bits toward the MSB.
  always_comb begin
    q_d = q_q;
    if (load) begin
      q_d = load_data;
    end else if (clear) begin
      q_d = '0;
    end else if (shift) begin
      if (DIR != 0) begin
        q_d = {q_q[WIDTH-2:0], 1'b0};
      end else begin
        q_d = {1'b0, q_q[WIDTH-1:1]};
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/piso_serializer.sv
// Parallel-in, serial-out serializer: accepts one word over a valid/ready port
// and emits it one bit per enabled cycle with frame-start/last markers.
module piso_serializer
  import piso_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int MSB_FIRST = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] load_data,
  input  logic             shift_en,
  output logic             sdo,
  output logic             sdo_valid,
  output logic             frame_start,
  output logic             frame_last,
  output logic             busy
);

  localparam int            CW      = CNT_W(WIDTH);
  localparam logic [CW-1:0] CNT_MAX = CW'(WIDTH - 1);
  localparam int            OUT_IDX = (MSB_FIRST != 0) ? WIDTH - 1 : 0;

  state_t           state_q;
  state_t           state_d;
  logic [CW-1:0]    cnt_q;
  logic [CW-1:0]    cnt_d;
  logic [WIDTH-1:0] sreg;

  logic inShift;
  logic lastBit;
  logic loadAccept;
  logic shiftStep;
  logic frameEnd;

  assign inShift = (state_q == ST_SHIFT);
  assign lastBit = inShift && (cnt_q == '0);

  // The ready term looks at shift_en so a new word can follow the last bit with no gap.
  always_comb begin
    load_ready = !inShift || (lastBit && shift_en);
    loadAccept = load_valid && load_ready;
    shiftStep  = inShift && shift_en && (cnt_q != '0);
    frameEnd   = lastBit && shift_en && !loadAccept;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (loadAccept) begin
      state_d = ST_SHIFT;
      cnt_d   = CNT_MAX;
    end else if (shiftStep) begin
      cnt_d = cnt_q - 1'b1;
    end else if (frameEnd) begin
      state_d = ST_IDLE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  shift_reg_en #(
    .WIDTH(WIDTH),
    .DIR  (MSB_FIRST)
  ) u_sreg (
    .clk      (clk),
    .rst      (rst),
    .load     (loadAccept),
    .clear    (frameEnd),
    .shift    (shiftStep),
    .load_data(load_data),
    .q        (sreg)
  );

  // The serial bit always comes from the register, never from load_data.
  always_comb begin
    busy        = inShift;
    sdo         = inShift ? sreg[OUT_IDX] : 1'b0;
    sdo_valid   = inShift && shift_en;
    frame_start = sdo_valid && (cnt_q == CNT_MAX);
    frame_last  = sdo_valid && (cnt_q == '0);
  end

endmodule

// File: tb/tb_piso_serializer.sv
// Self-checking bench for piso_serializer: MSB-first and LSB-first instances
// share stimulus and are compared every cycle against a word/bit-index model.
module tb_piso_serializer;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         loadValid;
  logic [W-1:0] loadData;
  logic         shiftEn;

  logic mReady, mSdo, mValid, mStart, mLast, mBusy;
  logic lReady, lSdo, lValid, lStart, lLast, lBusy;

  int nChecks = 0;
  int nFails  = 0;

  // Reference model: the word in flight and how many of its bits remain.
  logic [W-1:0] word;
  int           bitsLeft;

  logic msbBits[$];
  logic lsbBits[$];

  typedef struct {
    logic         lv;
    logic [W-1:0] data;
    logic         se;
    logic         sdo;
    logic         vld;
    logic         fs;
    logic         fl;
    logic         busy;
    logic         rdy;
  } vec_t;

  vec_t vecs[10];

  always #5 clk = ~clk;

  piso_serializer #(.WIDTH(W), .MSB_FIRST(1)) dutMsb (
    .clk(clk), .rst(rst), .load_valid(loadValid), .load_ready(mReady),
    .load_data(loadData), .shift_en(shiftEn), .sdo(mSdo), .sdo_valid(mValid),
    .frame_start(mStart), .frame_last(mLast), .busy(mBusy)
  );

  piso_serializer #(.WIDTH(W), .MSB_FIRST(0)) dutLsb (
    .clk(clk), .rst(rst), .load_valid(loadValid), .load_ready(lReady),
    .load_data(loadData), .shift_en(shiftEn), .sdo(lSdo), .sdo_valid(lValid),
    .frame_start(lStart), .frame_last(lLast), .busy(lBusy)
  );

  task automatic check1(input string name, input logic act, input logic exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("[TB] FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
    end
  endtask

  task automatic checkInt(input string name, input int act, input int exp);
    nChecks++;
    if (act != exp) begin
      nFails++;
      $display("[TB] FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  function automatic logic modelBit(input bit msb);
    int k;
    if (bitsLeft == 0) return 1'b0;
    k = W - bitsLeft;
    return msb ? word[W-1-k] : word[k];
  endfunction

  // Compare both instances with the model; optionally advance the model by one edge.
  task automatic checkOutput(input bit advance);
    logic eBusy, eVld, eFs, eFl, eRdy;
    eBusy = (bitsLeft > 0);
    eVld  = eBusy && shiftEn && !rst;
    eFs   = eVld && (bitsLeft == W);
    eFl   = eVld && (bitsLeft == 1);
    eRdy  = !eBusy || (bitsLeft == 1 && shiftEn);
    check1("msb load_ready", mReady, eRdy);
    check1("msb sdo", mSdo, modelBit(1'b1));
    check1("msb sdo_valid", mValid, eVld);
    check1("msb frame_start", mStart, eFs);
    check1("msb frame_last", mLast, eFl);
    check1("msb busy", mBusy, eBusy);
    check1("lsb load_ready", lReady, eRdy);
    check1("lsb sdo", lSdo, modelBit(1'b0));
    check1("lsb sdo_valid", lValid, eVld);
    check1("lsb frame_start", lStart, eFs);
    check1("lsb frame_last", lLast, eFl);
    check1("lsb busy", lBusy, eBusy);
    if (advance) begin
      if (mValid) msbBits.push_back(mSdo);
      if (lValid) lsbBits.push_back(lSdo);
      if (loadValid && eRdy) begin
        word     = loadData;
        bitsLeft = W;
      end else if (eBusy && shiftEn) begin
        bitsLeft--;
      end
    end
  endtask

  task automatic applyStimulus(input logic lv, input logic [W-1:0] d, input logic se);
    @(negedge clk);
    loadValid = lv;
    loadData  = d;
    shiftEn   = se;
    #1;
    checkOutput(1'b1);
  endtask

  task automatic pulseReset();
    @(negedge clk);
    #2;
    loadValid = 1'b0;
    rst       = 1'b1;
    bitsLeft  = 0;
    word      = '0;
    #1;
    checkOutput(1'b0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic runFrame(input logic [W-1:0] d);
    applyStimulus(1'b1, d, 1'b1);
    for (int i = 0; i < W; i++) applyStimulus(1'b0, '0, 1'b1);
  endtask

  task automatic checkBits(input string name, input bit msb, input logic [2*W-1:0] exp,
                           input int n);
    logic b;
    checkInt({name, " count"}, msb ? msbBits.size() : lsbBits.size(), n);
    for (int i = 0; i < n; i++) begin
      if (msb) b = (i < msbBits.size()) ? msbBits[i] : 1'bx;
      else     b = (i < lsbBits.size()) ? lsbBits[i] : 1'bx;
      check1(name, b, exp[n-1-i]);
    end
  endtask

  initial begin
    logic [2*W-1:0] expSeq;
    rst       = 1'b1;
    loadValid = 1'b0;
    loadData  = '0;
    shiftEn   = 1'b0;
    word      = '0;
    bitsLeft  = 0;
    #1;
    checkOutput(1'b0);
    @(negedge clk);
    rst = 1'b0;

    // Basic 0xA5 frame, checked against literal expectations.
    vecs[0] = '{1'b1, 8'hA5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[1] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[2] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[3] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[4] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[5] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[6] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[7] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[8] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
    vecs[9] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 10; i++) begin
      applyStimulus(vecs[i].lv, vecs[i].data, vecs[i].se);
      check1("vec sdo", mSdo, vecs[i].sdo);
      check1("vec sdo_valid", mValid, vecs[i].vld);
      check1("vec frame_start", mStart, vecs[i].fs);
      check1("vec frame_last", mLast, vecs[i].fl);
      check1("vec busy", mBusy, vecs[i].busy);
      check1("vec load_ready", mReady, vecs[i].rdy);
    end

    // Stall: bits advance only on enabled cycles.
    msbBits.delete();
    applyStimulus(1'b1, 8'hC3, 1'b0);
    begin
      logic [10:0] pat;
      pat = 11'b10011011111;
      for (int i = 10; i >= 0; i--) applyStimulus(1'b0, '0, pat[i]);
    end
    applyStimulus(1'b0, '0, 1'b1);
    checkBits("stall bits", 1'b1, {8'h00, 8'hC3}, W);

    // Back-to-back: second word offered during the first frame_last.
    msbBits.delete();
    applyStimulus(1'b1, 8'hA5, 1'b1);
    for (int i = 0; i < W - 1; i++) applyStimulus(1'b0, '0, 1'b1);
    applyStimulus(1'b1, 8'h3C, 1'b1);
    check1("b2b ready at last", mReady, 1'b1);
    for (int i = 0; i < W; i++) begin
      applyStimulus(1'b0, '0, 1'b1);
      if (i == 0) check1("b2b second start", mStart, 1'b1);
    end
    applyStimulus(1'b0, '0, 1'b1);
    checkBits("b2b bits", 1'b1, {8'hA5, 8'h3C}, 2 * W);

    // LSB first on the second instance.
    lsbBits.delete();
    runFrame(8'h01);
    applyStimulus(1'b0, '0, 1'b0);
    checkBits("lsb bits", 1'b0, {8'h00, 8'h80}, W);

    // Load offered mid-frame is ignored.
    msbBits.delete();
    applyStimulus(1'b1, 8'hA5, 1'b1);
    applyStimulus(1'b0, '0, 1'b1);
    applyStimulus(1'b0, '0, 1'b1);
    applyStimulus(1'b1, 8'hFF, 1'b1);
    check1("busy ignore ready", mReady, 1'b0);
    for (int i = 0; i < W - 3; i++) applyStimulus(1'b0, '0, 1'b1);
    applyStimulus(1'b0, '0, 1'b1);
    runFrame(8'h77);
    applyStimulus(1'b0, '0, 1'b1);
    checkBits("ignore bits", 1'b1, {8'hA5, 8'h77}, 2 * W);

    // Reset mid-frame aborts the word.
    msbBits.delete();
    applyStimulus(1'b1, 8'hA5, 1'b1);
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, '0, 1'b1);
    shiftEn = 1'b1;
    pulseReset();
    #1;
    checkOutput(1'b0);
    msbBits.delete();
    runFrame(8'h5A);
    applyStimulus(1'b0, '0, 1'b1);
    checkBits("post-reset bits", 1'b1, {8'h00, 8'h5A}, W);

    // Randomized traffic against the model, with occasional resets.
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 199) == 0) begin
        pulseReset();
      end else begin
        applyStimulus(1'($urandom_range(0, 1)), W'($urandom), ($urandom_range(0, 9) < 7));
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule

// File: doc/piso_serializer.md
# piso_serializer

Parallel-in, serial-out serializer with a valid/ready load port and a synchronous shift enable. It accepts one WIDTH-bit word, then emits it one bit per enabled cycle with frame-start and last-bit markers. It is the transmit end of a serial link whose receive end is a chain of enabled, asynchronously reset D flops that rebuilds the word.

## Interface
- WIDTH, 8, word length in bits; legal range ≥ 2
- MSB_FIRST, 1, 1 = bit WIDTH-1 leaves first; 0 = bit 0 leaves first
- clk  in  1  clock; all state changes on rising edge
- rst  in  1  reset, asynchronous, active-high
- load_valid  in  1  load_data is valid this cycle
- load_ready  out  1  serializer can accept a word this cycle
- load_data  in  WIDTH  word to serialize
- shift_en  in  1  synchronous enable; advance one bit when high
- sdo  out  1  current serial bit
- sdo_valid  out  1  sdo is consumed this cycle
- frame_start  out  1  sdo is the first bit of a word
- frame_last  out  1  sdo is the last bit of a word
- busy  out  1  a word is in progress (state SHIFT)

## Operation
- Storage:
  - shift register sreg[WIDTH-1:0]
  - down-counter cnt, $clog2(WIDTH) bits
  - state ∈ {IDLE, SHIFT}
- Load accept: a word is captured when load_valid && load_ready. load_valid with load_ready low is ignored and the data is not stored.
- load_ready = (state==IDLE) || (state==SHIFT && cnt==0 && shift_en).
- On accept:
  - sreg ← load_data
  - cnt ← WIDTH-1
  - state ← SHIFT
- sdo:
  - MSB_FIRST=1: sreg[WIDTH-1]
  - MSB_FIRST=0: sreg[0]
  - forced 0 in IDLE
- sdo_valid = (state==SHIFT) && shift_en.
- frame_start = sdo_valid && cnt==WIDTH-1.
- frame_last = sdo_valid && cnt==0.
- busy = (state==SHIFT).
- SHIFT, shift_en=1, cnt≠0:
  - shift sreg toward the output end, filling with 0
  - cnt ← cnt-1
- SHIFT, shift_en=1, cnt==0:
  - if a load is accepted the same cycle, reload and stay in SHIFT (back-to-back, no gap bit)
  - otherwise state ← IDLE and sreg ← 0
- SHIFT, shift_en=0: sreg, cnt and state hold; sdo stays stable.
- IDLE: shift_en has no effect.

## Timing
- Reset (asynchronous, immediate): state=IDLE, sreg=0, cnt=0. Outputs during and after reset:
  - sdo=0, sdo_valid=0, frame_start=0, frame_last=0, busy=0
  - load_ready=1
- Reset mid-frame aborts the word. No further bits of it are emitted, and the first cycle after release is IDLE.
- Load-to-first-bit latency is 1 cycle. A word accepted at edge N presents its first bit from N+1 and is valid when shift_en=1.
- A word takes exactly WIDTH enabled cycles. With shift_en held high, that is WIDTH consecutive sdo_valid cycles.
- Back-to-back frames: with load_valid high in the frame_last cycle, the next word's frame_start is the immediately following enabled cycle.
- load_ready depends combinationally on shift_en. The upstream side must not make load_valid depend on load_ready.
- No combinational path from load_data to sdo; sdo always comes from sreg.

## Structure
- Shared package / header `piso_pkg`:
  - state encodings ST_IDLE=1'b0, ST_SHIFT=1'b1
  - counter-width function CNT_W(WIDTH)
- Top-level `piso_serializer` contains:
  - the FSM
  - the counter
  - output decode
- One sub-module: `shift_reg_en`, a WIDTH-bit register with
  - asynchronous active-high reset
  - synchronous parallel load (priority) and shift enable
  - parameter DIR selecting the shift direction
  It is instantiated once.

## Test plan
- Basic frame: WIDTH=8, MSB_FIRST=1, load 0xA5, shift_en=1 constantly.
  - sdo = 1,0,1,0,0,1,0,1 on 8 consecutive sdo_valid cycles
  - frame_start on bit 1, frame_last on bit 8
  - busy falls after bit 8
- Stall: load 0xC3, shift_en pattern 1,0,0,1,1,0,1,1,1,1,1.
  - bits advance only on enabled cycles
  - sdo holds its value during 0s
  - 8 sdo_valid total, sequence 1,1,0,0,0,0,1,1
- Back-to-back: load 0xA5, then assert load_valid with 0x3C during frame_last.
  - 16 contiguous valid bits: A5 then 3C
  - no IDLE cycle between words
  - second frame_start directly after the first frame_last
- LSB first: MSB_FIRST=0, load 0x01.
  - first sdo=1, then seven 0s
  - frame_last on the 8th bit
- Ignore while busy: during a 0xA5 frame, present load_valid=1 with 0xFF at bit 3.
  - load_ready=0, and 0xA5 completes unchanged
  - after IDLE the next accepted word is the one presented then
- Reset mid-frame: assert rst after bit 3 of 0xA5.
  - all outputs go to reset values immediately
  - after release: load_ready=1, no residual bits, a new 0x5A serializes correctly
